sync_ram_bank: RTL and testbench
================================

# sync_ram_bank

Parametrised single-port synchronous RAM bank with per-byte write enables, a registered read path with valid strobe, and a built-in clear sequencer that zeroes the whole array after reset or on request. It replaces the fixed 32-bit tri-stated data memory in the datapath. `Dout` is always driven and qualified by `Dvalid`, so several banks can feed a mux instead of sharing a bus.

## Interface
- `DATA_WIDTH`, default 32: word width. Must be a multiple of 8.
- `ADDR_WIDTH`, default 8: address width. DEPTH = 1 << ADDR_WIDTH.
- Derived localparam `BYTES` = DATA_WIDTH/8.

- `clk`, input, 1: rising-edge clock. The only clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `clear`, input, 1: request a full-array zero fill (level-sampled).
- `Din`, input, DATA_WIDTH: write data.
- `addr`, input, ADDR_WIDTH: read/write address.
- `writeEn`, input, 1: write request.
- `byteEn`, input, BYTES: per-byte write mask. Bit i covers `Din[8i+7:8i]`.
- `read`, input, 1: read request.
- `Dout`, output, DATA_WIDTH: registered read data. Holds its value between reads.
- `Dvalid`, output, 1: one-cycle strobe marking new `Dout`.
- `busy`, output, 1: clear sequencer active. All requests are ignored while it is high.

## Operation
- Two states: CLEAR and IDLE. A counter `clr_addr` (ADDR_WIDTH bits) drives the clear.
- **Reset** (rising edge with `rst_n`=0):
  - state ← CLEAR, `clr_addr` ← 0.
  - `busy` ← 1, `Dvalid` ← 0, `Dout` ← 0.
  - Array contents are not touched on the reset edge itself.
- **CLEAR**:
  - Each edge writes 0 to `mem[clr_addr]` and increments `clr_addr`.
  - On the edge that writes DEPTH-1: state ← IDLE, `busy` ← 0.
  - The counter wraps to 0, and no extra write occurs.
  - `writeEn`, `read` and `clear` are ignored; `Dvalid` stays 0.
- **IDLE, write** (`writeEn`=1): for each i with `byteEn[i]`=1, `mem[addr]` byte i ← `Din` byte i. Other bytes keep their value. `byteEn`=0 makes the write a no-op.
- **IDLE, read** (`read`=1): `Dout` ← `mem[addr]` and `Dvalid` ← 1. Otherwise `Dvalid` ← 0 and `Dout` holds.
- **Simultaneous read and write, same address**: read-first. `Dout` returns the pre-write word, and the write still commits.
- **clear in IDLE** (`clear`=1): state ← CLEAR, `clr_addr` ← 0, `busy` ← 1 on that edge.
  - `clear` has priority over a same-cycle read or write, which are dropped.
- **Reset mid-CLEAR**: the sequence restarts from address 0.
- **`clear` held high**: each re-entry from IDLE restarts the sequence, so holding `clear` keeps the bank busy.

## Timing
- After reset, `busy` is high for exactly DEPTH edges with `rst_n`=1.
  - Counting edge 1 as the first edge with `rst_n`=1, `busy` falls after edge DEPTH.
  - The first accepted request is sampled at edge DEPTH+1.
- Read latency is 1 cycle.
  - Request sampled at edge N → `Dout`/`Dvalid` valid after edge N, for one cycle.
  - Back-to-back reads give one word per cycle.
- A write sampled at edge N is visible to a read sampled at edge N+1.
- `busy` rises on the edge that samples `clear`=1 in IDLE. It falls DEPTH edges later.
- Reset values:
  - `Dout`=0, `Dvalid`=0, `busy`=1.
- No combinational path from any input to any output.

## Test plan
Benches use DATA_WIDTH=32 and ADDR_WIDTH=4 (DEPTH=16).

- **Reset and clear timing**: hold `rst_n`=0 for 2 cycles, then release.
  - `busy`=1 for exactly 16 edges.
  - Reads of addresses 0..15 return 0x00000000 with `Dvalid`=1, one cycle after each request.
- **Byte-enable write**: write 0xAABBCCDD to addr 3 with `byteEn`=4'b1111, then 0x11223344 with `byteEn`=4'b0101.
  - A read of addr 3 returns 0xAA22CC44.
- **Read-first collision**: addr 7 holds 0x12345678. In one cycle, `read`=1 and `writeEn`=1 with `Din`=0xDEADBEEF, `byteEn`=4'hF.
  - `Dout`=0x12345678.
  - The next read returns 0xDEADBEEF.
- **Busy gating**: assert `clear` in IDLE, then issue writes and reads during the 16 busy cycles.
  - `Dvalid` stays 0.
  - After `busy` falls, every address reads 0.
- **Reset mid-clear**: pulse `rst_n`=0 at clear step 9.
  - `busy` then stays high for 16 more edges.
  - All addresses read 0.
- **Streaming and hold**: read addrs 1,2,3 back-to-back after writing 0x1, 0x2, 0x3.
  - `Dvalid` is high for 3 consecutive cycles with `Dout`=0x1, 0x2, 0x3.
  - After `read` drops, `Dout` holds 0x3 and `Dvalid`=0.

Source files
------------

// File: rtl/sync_ram_bank.sv
// Single-port synchronous RAM bank with byte-lane write enables, a registered read-first read port,
// and a clear sequencer that zero-fills the whole array after reset or on request.
module sync_ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   Din,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    writeEn,
    input  logic [DATA_WIDTH/8-1:0] byteEn,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   Dout,
    output logic                    Dvalid,
    output logic                    busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;
    logic                    dvalid_reg;

    logic                    clearing;
    logic                    accept;
    logic                    rd_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [BYTES-1:0]        mem_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                clr_addr_next = clr_addr_reg + ADDR_ONE;
                if (clr_addr_reg == '1) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    // A clear request in IDLE wins over any same-cycle read or write.
    assign clearing  = (state_reg == CLEAR);
    assign accept    = (state_reg == IDLE) && !clear;
    assign rd_en     = accept && read;
    assign mem_we    = rst_n && (clearing || (accept && writeEn));
    assign mem_addr  = clearing ? clr_addr_reg : addr;
    assign mem_wdata = clearing ? '0 : Din;
    assign mem_mask  = clearing ? '1 : byteEn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvalid_reg <= 1'b0;
        end else begin
            dvalid_reg <= rd_en;
        end
    end

    // One narrow array per byte lane so each lane maps onto its own write enable.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (mem_we && mem_mask[gi]) begin
                    mem_lane[mem_addr] <= mem_wdata[8*gi +: 8];
                end
            end

            // Read sees the pre-write word on a same-address collision.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_q_reg <= '0;
                end else if (rd_en) begin
                    lane_q_reg <= mem_lane[addr];
                end
            end

            assign Dout[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    assign Dvalid = dvalid_reg;
    assign busy   = clearing;

endmodule

// File: tb/tb_sync_ram_bank.sv
// Directed and random stimulus for sync_ram_bank, checked every edge against a word-level
// model of the bank (clear countdown, read-first access, byte-masked merge).
module tb_sync_ram_bank;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NB    = 4;

    logic          clk = 1'b0;
    logic          rst_n, clear, writeEn, read;
    logic [AW-1:0] addr;
    logic [DW-1:0] Din, Dout;
    logic [NB-1:0] byteEn;
    logic          Dvalid, busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_dout;
    logic          m_dvalid;
    int            m_busy_left;

    always #5 clk = ~clk;

    sync_ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .Din(Din), .addr(addr),
        .writeEn(writeEn), .byteEn(byteEn), .read(read),
        .Dout(Dout), .Dvalid(Dvalid), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bank behaviour after one rising edge, given the inputs sampled on it.
    task automatic model_edge();
        if (!rst_n) begin
            m_busy_left = DEPTH;
            m_dout      = '0;
            m_dvalid    = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            m_dvalid = 1'b0;
            if (m_busy_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else if (clear) begin
            m_busy_left = DEPTH;
            m_dvalid    = 1'b0;
        end else begin
            m_dvalid = read;
            if (read) m_dout = m_mem[addr];
            if (writeEn) begin
                for (int b = 0; b < NB; b++) begin
                    if (byteEn[b]) m_mem[addr][8*b +: 8] = Din[8*b +: 8];
                end
            end
        end
    endtask

    task automatic cycle(input logic rn, input logic clr, input logic we, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        rst_n = rn; clear = clr; writeEn = we; read = rd; addr = a; Din = d; byteEn = be;
        @(posedge clk);
        model_edge();
        #1;
        check("dout", Dout, m_dout);
        check("dvalid", {31'b0, Dvalid}, {31'b0, m_dvalid});
        check("busy", {31'b0, busy}, {31'b0, (m_busy_left > 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, a, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, a, d, be);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            check(tag, Dout, 32'h0);
        end
    endtask

    initial begin
        m_busy_left = DEPTH;
        m_dout      = '0;
        m_dvalid    = 1'b0;

        // Reset and post-reset clear timing; reads during busy must be ignored
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_dout", Dout, 32'h0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, AW'(i), 32'hFFFF_FFFF, '1);
        check("busy_fell", {31'b0, busy}, 32'h0);
        read_all_zero("post_reset_zero");

        // Byte-enable merge
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        wr(4'd3, 32'h55555555, 4'b0000);
        rd(4'd3);
        check("byte_en", Dout, 32'hAA22CC44);

        // Read-first collision
        wr(4'd7, 32'h12345678, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF);
        check("collide_old", Dout, 32'h12345678);
        rd(4'd7);
        check("collide_new", Dout, 32'hDEADBEEF);

        // Clear in IDLE drops the same-cycle read, then busy gates everything
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 32'h0BAD_0BAD, 4'hF);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, AW'($urandom_range(0, DEPTH-1)), $urandom, 4'($urandom));
            check("gated_dvalid", {31'b0, Dvalid}, 32'h0);
        end
        read_all_zero("post_clear_zero");

        // Reset mid-clear restarts the full sequence
        wr(4'd5, 32'hCAFEF00D, 4'hF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle(8);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(DEPTH - 1);
        check("midrst_busy", {31'b0, busy}, 32'h1);
        idle(1);
        check("midrst_done", {31'b0, busy}, 32'h0);
        read_all_zero("midrst_zero");

        // Streaming reads and hold
        wr(4'd1, 32'h1, 4'hF);
        wr(4'd2, 32'h2, 4'hF);
        wr(4'd3, 32'h3, 4'hF);
        rd(4'd1); check("stream1", Dout, 32'h1);
        rd(4'd2); check("stream2", Dout, 32'h2);
        rd(4'd3); check("stream3", Dout, 32'h3);
        idle(2);
        check("hold_dout", Dout, 32'h3);
        check("hold_dvalid", {31'b0, Dvalid}, 32'h0);

        // Random traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 79) != 0, $urandom_range(0, 39) == 0,
                  1'($urandom), 1'($urandom), AW'($urandom), $urandom, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
